// File: rtl/regimm_pc_unit.sv
// regimm_pc_unit: architectural PC and branch/jump resolution for the MIPS32
// single-cycle core. It decodes BLTZ/BGEZ/BLTZAL/BGEZAL, BEQ/BNE/BLEZ/BGTZ
// and J/JAL, computes the next PC, and traps (sticky invpc) on any taken
// target that falls outside instruction memory.
//
// Build option: BRANCH_DELAY_SLOT_EN
//   defined   - a taken branch retires through one delay slot (DELAY state),
//               flush is never raised, linkData = pc + 8.
//   undefined - a taken branch redirects immediately and pulses flush,
//               linkData = pc + 4.
module regimm_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          IADDR_W  = 10
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               stall,
    input  logic               iValid,
    input  logic [5:0]         iOp,
    input  logic [4:0]         iRt,
    input  logic [15:0]        imm16,
    input  logic [25:0]        jIndex,
    input  logic [31:0]        rsData,
    input  logic [31:0]        rtData,
    output logic [31:0]        pc,
    output logic [IADDR_W-1:0] iAddr,
    output logic               flush,
    output logic               brTaken,
    output logic               linkWe,
    output logic [31:0]        linkData,
    output logic               invpc,
    output logic [15:0]        brCount
);

    // Opcodes and REGIMM sub-codes handled here.
    localparam logic [5:0] OP_REGIMM = 6'd1;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_BLEZ   = 6'd6;
    localparam logic [5:0] OP_BGTZ   = 6'd7;

    localparam logic [4:0] RT_BLTZ   = 5'd0;
    localparam logic [4:0] RT_BGEZ   = 5'd1;
    localparam logic [4:0] RT_BLTZAL = 5'd16;
    localparam logic [4:0] RT_BGEZAL = 5'd17;

    // First byte address past instruction memory; 33 bits so a memory that
    // ends exactly at 2^32 still compares correctly.
    localparam logic [32:0] MEM_END = {1'b0, RESET_PC} + (33'd4 << IADDR_W);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DELAY = 2'd1,
        TRAP  = 2'd2
    } state_t;

    // Decoded branch attributes for the instruction presented this cycle.
    typedef struct packed {
        logic is_br;    // opcode/sub-code is a branch or jump
        logic is_jump;  // target comes from jIndex rather than imm16
        logic is_link;  // writes the return address to $31
        logic cond;     // branch condition holds
    } br_dec_t;

    state_t      state;
    br_dec_t     dec;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic [31:0] link_addr;
    logic [31:0] pc_off;
    logic        rs_neg;
    logic        rs_zero;
    logic        target_ok;
    logic        eval;
    logic        take;
    logic        link_req;
    logic        trap_hit;
    logic        unused_pc_off_bits;

`ifdef BRANCH_DELAY_SLOT_EN
    logic [31:0] saved_target;
`endif

    // Address arithmetic shared by all branch kinds.
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign j_target  = {pc_plus4[31:28], jIndex, 2'b00};
    assign target    = dec.is_jump ? j_target : br_target;

`ifdef BRANCH_DELAY_SLOT_EN
    // Return past the delay-slot instruction.
    assign link_addr = pc + 32'd8;
`else
    assign link_addr = pc_plus4;
`endif

    // Word index into instruction memory relative to its base.
    assign pc_off             = pc - RESET_PC;
    assign iAddr              = pc_off[IADDR_W+1:2];
    assign unused_pc_off_bits = ^{pc_off[31:IADDR_W+2], pc_off[1:0]};

    assign rs_neg  = rsData[31];
    assign rs_zero = (rsData == 32'd0);

    // Decode the branch kind and evaluate its signed condition on rs.
    always_comb begin
        dec = '0;
        case (iOp)
            OP_REGIMM: begin
                case (iRt)
                    RT_BLTZ, RT_BLTZAL: begin
                        dec.is_br   = 1'b1;
                        dec.cond    = rs_neg;
                        dec.is_link = iRt[4];
                    end
                    RT_BGEZ, RT_BGEZAL: begin
                        dec.is_br   = 1'b1;
                        dec.cond    = ~rs_neg;
                        dec.is_link = iRt[4];
                    end
                    default: dec = '0;
                endcase
            end
            OP_J: begin
                dec.is_br   = 1'b1;
                dec.is_jump = 1'b1;
                dec.cond    = 1'b1;
            end
            OP_JAL: begin
                dec.is_br   = 1'b1;
                dec.is_jump = 1'b1;
                dec.is_link = 1'b1;
                dec.cond    = 1'b1;
            end
            OP_BEQ: begin
                dec.is_br = 1'b1;
                dec.cond  = (rsData == rtData);
            end
            OP_BNE: begin
                dec.is_br = 1'b1;
                dec.cond  = (rsData != rtData);
            end
            OP_BLEZ: begin
                dec.is_br = 1'b1;
                dec.cond  = rs_neg | rs_zero;
            end
            OP_BGTZ: begin
                dec.is_br = 1'b1;
                dec.cond  = ~rs_neg & ~rs_zero;
            end
            default: dec = '0;
        endcase
    end

    // Target must land inside [RESET_PC, MEM_END).
    assign target_ok = ({1'b0, target} >= {1'b0, RESET_PC}) &&
                       ({1'b0, target} <  MEM_END);

    // Branches are only evaluated in RUN on a live, unstalled cycle; the
    // delay slot and the trap state never look at the decoder.
    assign eval     = iValid && !stall && (state == RUN);
    assign take     = eval && dec.is_br && dec.cond;
    assign link_req = eval && dec.is_link;
    assign trap_hit = take && !target_ok;

    // PC/state register with registered pulse, link and trap outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            flush    <= 1'b0;
            brTaken  <= 1'b0;
            linkWe   <= 1'b0;
            linkData <= 32'd0;
            invpc    <= 1'b0;
            brCount  <= 16'd0;
`ifdef BRANCH_DELAY_SLOT_EN
            saved_target <= 32'd0;
`endif
        end else begin
            // Pulses default low; stall and TRAP simply never set them.
            flush   <= 1'b0;
            brTaken <= 1'b0;
            linkWe  <= 1'b0;
            if (!stall) begin
                case (state)
                    RUN: begin
                        if (trap_hit) begin
                            // PC freezes on the offending instruction.
                            state <= TRAP;
                            invpc <= 1'b1;
                        end else begin
                            if (link_req) begin
                                linkWe   <= 1'b1;
                                linkData <= link_addr;
                            end
                            if (take) begin
                                brTaken <= 1'b1;
                                if (brCount != 16'hFFFF)
                                    brCount <= brCount + 16'd1;
`ifdef BRANCH_DELAY_SLOT_EN
                                pc           <= pc_plus4;
                                saved_target <= target;
                                state        <= DELAY;
`else
                                pc    <= target;
                                flush <= 1'b1;
`endif
                            end else begin
                                pc <= pc_plus4;
                            end
                        end
                    end
`ifdef BRANCH_DELAY_SLOT_EN
                    DELAY: begin
                        pc    <= saved_target;
                        state <= RUN;
                    end
`endif
                    TRAP: begin
                        invpc <= 1'b1;
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regimm_pc_unit.sv
// Self-checking bench for regimm_pc_unit: table of single-branch vectors run
// from reset, plus hand sequences for back-to-back branches, stall, trap hold,
// reset/stall priority and (delay-slot builds) stall/reset inside DELAY.
module tb_regimm_pc_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        reset, stall, iValid;
    logic [5:0]  iOp;
    logic [4:0]  iRt;
    logic [15:0] imm16;
    logic [25:0] jIndex;
    logic [31:0] rsData, rtData;
    logic [31:0] pc;
    logic [9:0]  iAddr;
    logic        flush, brTaken, linkWe, invpc;
    logic [31:0] linkData;
    logic [15:0] brCount;

    always #5 CLK = ~CLK;

    regimm_pc_unit #(.RESET_PC(RPC), .IADDR_W(10)) dut (
        .CLK(CLK), .reset(reset), .stall(stall), .iValid(iValid),
        .iOp(iOp), .iRt(iRt), .imm16(imm16), .jIndex(jIndex),
        .rsData(rsData), .rtData(rtData), .pc(pc), .iAddr(iAddr),
        .flush(flush), .brTaken(brTaken), .linkWe(linkWe),
        .linkData(linkData), .invpc(invpc), .brCount(brCount)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        bt, fl, lw, inv;
        logic [31:0] ld;
        logic [15:0] cnt;
        logic        chk_pulse, chk_ld, chk_cnt;
    } exp_t;

    typedef struct {
        string       name;
        int          idle_n;
        logic        v;
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [25:0] ji;
        logic [31:0] rs, rtd;
        logic        tk, lk, tr;
        logic [31:0] tg;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(string n, logic [31:0] p, logic bt, logic fl,
                                logic lw, logic inv, logic [15:0] cnt);
        exp_t e;
        e.name = n; e.pc = p; e.bt = bt; e.fl = fl; e.lw = lw; e.inv = inv;
        e.ld = 32'd0; e.cnt = cnt;
        e.chk_pulse = 1'b1; e.chk_ld = 1'b0; e.chk_cnt = 1'b1;
        return e;
    endfunction

    function automatic vec_t mkv(string n, int idl, logic v, logic [5:0] op,
                                 logic [4:0] rt, logic [15:0] imm, logic [25:0] ji,
                                 logic [31:0] rs, logic [31:0] rtd, logic tk,
                                 logic lk, logic tr, logic [31:0] tg);
        vec_t t;
        t.name = n; t.idle_n = idl; t.v = v; t.op = op; t.rt = rt; t.imm = imm;
        t.ji = ji; t.rs = rs; t.rtd = rtd; t.tk = tk; t.lk = lk; t.tr = tr; t.tg = tg;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; iValid = 1'b0;
        iOp = 6'd0; iRt = 5'd0; imm16 = 16'd0; jIndex = 26'd0;
        rsData = 32'd0; rtData = 32'd0;
    endtask

    task automatic drv(input logic v, input logic [5:0] op, input logic [4:0] rt,
                       input logic [15:0] imm, input logic [25:0] ji,
                       input logic [31:0] rs, input logic [31:0] rtd);
        reset = 1'b0; stall = 1'b0; iValid = v;
        iOp = op; iRt = rt; imm16 = imm; jIndex = ji; rsData = rs; rtData = rtd;
    endtask

    // One clock; compare the oldest scoreboard entry 1 time unit after the edge.
    task automatic tick();
        exp_t        e;
        logic [31:0] d;
        @(posedge CLK);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            d = e.pc - RPC;
            chk({e.name, ".pc"}, pc, e.pc);
            chk({e.name, ".iAddr"}, {22'd0, iAddr}, {22'd0, d[11:2]});
            chk({e.name, ".invpc"}, {31'd0, invpc}, {31'd0, e.inv});
            if (e.chk_pulse) begin
                chk({e.name, ".brTaken"}, {31'd0, brTaken}, {31'd0, e.bt});
                chk({e.name, ".flush"}, {31'd0, flush}, {31'd0, e.fl});
                chk({e.name, ".linkWe"}, {31'd0, linkWe}, {31'd0, e.lw});
            end
            if (e.chk_ld)  chk({e.name, ".linkData"}, linkData, e.ld);
            if (e.chk_cnt) chk({e.name, ".brCount"}, {16'd0, brCount}, {16'd0, e.cnt});
        end
    endtask

    task automatic do_reset(input string nm);
        exp_t e;
        reset = 1'b1;
        e = mk(nm, RPC, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        e.chk_ld = 1'b1;
        sb.push_back(e);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        t;
        exp_t        e;
        logic [31:0] start;
        logic [31:0] nxt;

        // name, idle, v, op, rt, imm, jIndex, rs, rt, taken, link, trap, target
        vt.push_back(mkv("bltz_t",     2, 1, 6'd1, 5'd0,  16'hFFFF, 26'd0, 32'hFFFFFFFF, 32'd0, 1, 0, 0, 32'h0040_0008));
        vt.push_back(mkv("bltz_nt",    2, 1, 6'd1, 5'd0,  16'hFFFF, 26'd0, 32'h00000004, 32'd0, 0, 0, 0, 32'd0));
        vt.push_back(mkv("bgezal_t",   0, 1, 6'd1, 5'd17, 16'h0002, 26'd0, 32'h00000000, 32'd0, 1, 1, 0, 32'h0040_000C));
        vt.push_back(mkv("bltzal_nt",  0, 1, 6'd1, 5'd16, 16'h0002, 26'd0, 32'h00000005, 32'd0, 0, 1, 0, 32'd0));
        vt.push_back(mkv("bgez_t",     0, 1, 6'd1, 5'd1,  16'h0100, 26'd0, 32'h7FFFFFFF, 32'd0, 1, 0, 0, 32'h0040_0404));
        vt.push_back(mkv("beq_t",      4, 1, 6'd4, 5'd0,  16'h0010, 26'd0, 32'h00001234, 32'h00001234, 1, 0, 0, 32'h0040_0054));
        vt.push_back(mkv("bne_nt",     4, 1, 6'd5, 5'd0,  16'h0010, 26'd0, 32'h00001234, 32'h00001234, 0, 0, 0, 32'd0));
        vt.push_back(mkv("bne_t",      0, 1, 6'd5, 5'd0,  16'h0001, 26'd0, 32'h00000001, 32'h00000002, 1, 0, 0, 32'h0040_0008));
        vt.push_back(mkv("blez_neg",   0, 1, 6'd6, 5'd0,  16'h0003, 26'd0, 32'h80000000, 32'd0, 1, 0, 0, 32'h0040_0010));
        vt.push_back(mkv("blez_zero",  0, 1, 6'd6, 5'd0,  16'h0003, 26'd0, 32'h00000000, 32'd0, 1, 0, 0, 32'h0040_0010));
        vt.push_back(mkv("bgtz_zero",  0, 1, 6'd7, 5'd0,  16'h0003, 26'd0, 32'h00000000, 32'd0, 0, 0, 0, 32'd0));
        vt.push_back(mkv("j",          0, 1, 6'd2, 5'd0,  16'h0000, 26'h0100010, 32'd0, 32'd0, 1, 0, 0, 32'h0040_0040));
        vt.push_back(mkv("jal",        0, 1, 6'd3, 5'd0,  16'h0000, 26'h0100020, 32'd0, 32'd0, 1, 1, 0, 32'h0040_0080));
        vt.push_back(mkv("rtype",      0, 1, 6'd0, 5'd0,  16'h0004, 26'd0, 32'hFFFFFFFF, 32'd0, 0, 0, 0, 32'd0));
        vt.push_back(mkv("regimm_rt2", 0, 1, 6'd1, 5'd2,  16'h0004, 26'd0, 32'hFFFFFFFF, 32'd0, 0, 0, 0, 32'd0));
        vt.push_back(mkv("bubble_j",   0, 0, 6'd2, 5'd0,  16'h0000, 26'h0100010, 32'd0, 32'd0, 0, 0, 0, 32'd0));
        vt.push_back(mkv("beq_top",    0, 1, 6'd4, 5'd0,  16'h03FE, 26'd0, 32'd7, 32'd7, 1, 0, 0, 32'h0040_0FFC));
        vt.push_back(mkv("beq_end",    0, 1, 6'd4, 5'd0,  16'h03FF, 26'd0, 32'd7, 32'd7, 1, 0, 1, 32'd0));
        vt.push_back(mkv("beq_below",  0, 1, 6'd4, 5'd0,  16'hFFFE, 26'd0, 32'd7, 32'd7, 1, 0, 1, 32'd0));
        vt.push_back(mkv("bgtz_far",   0, 1, 6'd7, 5'd0,  16'h7FFF, 26'd0, 32'd1, 32'd0, 1, 0, 1, 32'd0));
        vt.push_back(mkv("j_low",      0, 1, 6'd2, 5'd0,  16'h0000, 26'h0000000, 32'd0, 32'd0, 1, 0, 1, 32'd0));

        idle();

        // Reset then three idle cycles.
        do_reset("reset");
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(mk($sformatf("idle%0d", k), RPC + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
            tick();
        end

        // Table vectors, each from a fresh reset.
        foreach (vt[i]) begin
            t = vt[i];
            do_reset({t.name, ".rst"});
            for (int k = 1; k <= t.idle_n; k++) begin
                sb.push_back(mk({t.name, ".pre"}, RPC + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
                tick();
            end
            start = RPC + 32'(4 * t.idle_n);
            drv(t.v, t.op, t.rt, t.imm, t.ji, t.rs, t.rtd);
            if (t.tr) begin
                e = mk(t.name, start, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
                e.chk_pulse = 1'b0;
                e.chk_cnt = 1'b0;
                sb.push_back(e);
                tick();
                idle();
                for (int k = 1; k <= 5; k++) begin
                    e = mk({t.name, ".hold"}, start, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
                    e.chk_cnt = 1'b0;
                    sb.push_back(e);
                    tick();
                end
                do_reset({t.name, ".clear"});
            end else begin
`ifdef BRANCH_DELAY_SLOT_EN
                e = mk(t.name, start + 32'd4, t.tk, 1'b0, t.lk, 1'b0, {15'd0, t.tk});
                e.chk_ld = t.lk;
                e.ld = start + 32'd8;
                sb.push_back(e);
                tick();
                idle();
                nxt = t.tk ? t.tg : start + 32'd8;
                sb.push_back(mk({t.name, ".slot"}, nxt, 1'b0, 1'b0, 1'b0, 1'b0, {15'd0, t.tk}));
                tick();
`else
                nxt = t.tk ? t.tg : start + 32'd4;
                e = mk(t.name, nxt, t.tk, t.tk, t.lk, 1'b0, {15'd0, t.tk});
                e.chk_ld = t.lk;
                e.ld = start + 32'd4;
                sb.push_back(e);
                tick();
                idle();
                sb.push_back(mk({t.name, ".next"}, nxt + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, {15'd0, t.tk}));
                tick();
`endif
            end
        end

        // Back-to-back taken branches: BEQ (+1 word) then BNE (+2 words).
        do_reset("b2b.rst");
        drv(1'b1, 6'd4, 5'd0, 16'h0001, 26'd0, 32'd3, 32'd3);
`ifdef BRANCH_DELAY_SLOT_EN
        sb.push_back(mk("b2b.first", RPC + 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1));
        tick();
        drv(1'b1, 6'd5, 5'd0, 16'h0002, 26'd0, 32'd3, 32'd4);
        sb.push_back(mk("b2b.slot", RPC + 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        tick();
        idle();
        sb.push_back(mk("b2b.after", RPC + 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        tick();
`else
        sb.push_back(mk("b2b.first", RPC + 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1));
        tick();
        drv(1'b1, 6'd5, 5'd0, 16'h0002, 26'd0, 32'd3, 32'd4);
        sb.push_back(mk("b2b.second", RPC + 32'h14, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2));
        tick();
        idle();
        sb.push_back(mk("b2b.after", RPC + 32'h18, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2));
        tick();
`endif

        // Stall in RUN with a taken branch presented.
        do_reset("stallrun.rst");
        drv(1'b1, 6'd4, 5'd0, 16'h0001, 26'd0, 32'd9, 32'd9);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk("stallrun.hold", RPC, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
            tick();
        end
        stall = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        sb.push_back(mk("stallrun.go", RPC + 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1));
`else
        sb.push_back(mk("stallrun.go", RPC + 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1));
`endif
        tick();
        idle();

        // Reset and stall together: reset wins.
        do_reset("rststall.rst");
        for (int k = 1; k <= 2; k++) begin
            sb.push_back(mk("rststall.pre", RPC + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
            tick();
        end
        drv(1'b1, 6'd2, 5'd0, 16'h0000, 26'h0100010, 32'd0, 32'd0);
        stall = 1'b1;
        do_reset("rststall.both");
        idle();
        sb.push_back(mk("rststall.after", RPC + 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        tick();

`ifdef BRANCH_DELAY_SLOT_EN
        // Stall for three cycles inside DELAY, then release to the target.
        do_reset("dstall.rst");
        drv(1'b1, 6'd4, 5'd0, 16'h0001, 26'd0, 32'd1, 32'd1);
        sb.push_back(mk("dstall.br", RPC + 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1));
        tick();
        idle();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk("dstall.hold", RPC + 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
            tick();
        end
        stall = 1'b0;
        sb.push_back(mk("dstall.target", RPC + 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        tick();
        sb.push_back(mk("dstall.next", RPC + 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        tick();

        // Reset inside DELAY discards the saved target (0x00400018).
        do_reset("dreset.rst");
        drv(1'b1, 6'd4, 5'd0, 16'h0005, 26'd0, 32'd1, 32'd1);
        sb.push_back(mk("dreset.br", RPC + 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1));
        tick();
        idle();
        do_reset("dreset.mid");
        sb.push_back(mk("dreset.a1", RPC + 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        tick();
        sb.push_back(mk("dreset.a2", RPC + 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        tick();
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
